// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: ROB/register widths, the CDB bus record
// and the per-entry record held in the ROB.
package reorder_buffer_pkg;
  localparam int ROB_WIDTH = 3;
  localparam int REG_WIDTH = 5;
  localparam int ROB_DEPTH = 1 << ROB_WIDTH;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic                 dest;
    logic                 fpr;
    logic [REG_WIDTH-1:0] arch_num;
    logic [31:0]          data;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, CDB capture, operand reads, in-order commit.
// Optional macro ROB_READ_BYPASS_EN forwards same-cycle CDB results to the read ports.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int N_CDB = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue,
  input  logic                 issue_dest,
  input  logic                 issue_fpr,
  input  logic [REG_WIDTH-1:0] issue_arch_num,
  output logic [ROB_WIDTH-1:0] issue_tag,
  output logic                 rob_full,
  input  cdb_t                 cdb [N_CDB],
  input  logic [ROB_WIDTH-1:0] read_tag [2],
  output cdb_t                 rob_read [2],
  input  logic                 commit_stall,
  output logic                 commit,
  output logic                 commit_gpr,
  output logic                 commit_fpr,
  output logic [REG_WIDTH-1:0] commit_arch_num,
  output logic [ROB_WIDTH-1:0] commit_tag,
  output logic [31:0]          commit_data
);

  localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH+1)'(ROB_DEPTH);

  rob_entry_t           entries [ROB_DEPTH];
  logic [ROB_WIDTH-1:0] head;
  logic [ROB_WIDTH-1:0] tail;
  logic [ROB_WIDTH:0]   count;
  logic [ROB_WIDTH:0]   count_next;
  logic                 issue_ok;
  logic                 empty;

  assign rob_full  = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign issue_ok  = issue && !rob_full;
  assign issue_tag = tail;

  assign commit          = !empty && entries[head].done && !commit_stall;
  assign commit_gpr      = commit && entries[head].dest && !entries[head].fpr;
  assign commit_fpr      = commit && entries[head].dest && entries[head].fpr;
  assign commit_arch_num = entries[head].arch_num;
  assign commit_tag      = head;
  assign commit_data     = entries[head].data;

  always_comb begin
    count_next = count;
    unique case ({issue_ok, commit})
      2'b10:   count_next = count + (ROB_WIDTH+1)'(1);
      2'b01:   count_next = count - (ROB_WIDTH+1)'(1);
      default: count_next = count;
    endcase
  end

  // Only busy/done and the pointers are flushed; payload fields are don't-care until re-issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries[i].busy <= 1'b0;
        entries[i].done <= 1'b0;
      end
    end else begin
      // Later CDB ports override earlier ones on a (protocol-violating) tag collision.
      for (int k = 0; k < N_CDB; k++) begin
        if (cdb[k].valid && entries[cdb[k].tag].busy) begin
          entries[cdb[k].tag].done <= 1'b1;
          entries[cdb[k].tag].data <= cdb[k].data;
        end
      end
      if (issue_ok) begin
        entries[tail].busy     <= 1'b1;
        entries[tail].done     <= 1'b0;
        entries[tail].dest     <= issue_dest;
        entries[tail].fpr      <= issue_fpr;
        entries[tail].arch_num <= issue_arch_num;
        tail                   <= tail + ROB_WIDTH'(1);
      end
      if (commit) begin
        entries[head].busy <= 1'b0;
        head               <= head + ROB_WIDTH'(1);
      end
      count <= count_next;
    end
  end

  // The read record reuses cdb_t: its valid field carries the entry's done bit.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rob_read[i].valid = entries[read_tag[i]].done;
      rob_read[i].tag   = read_tag[i];
      rob_read[i].data  = entries[read_tag[i]].data;
`ifdef ROB_READ_BYPASS_EN
      for (int k = 0; k < N_CDB; k++) begin
        if (cdb[k].valid && (cdb[k].tag == read_tag[i])) begin
          rob_read[i].valid = 1'b1;
          rob_read[i].data  = cdb[k].data;
        end
      end
`endif
    end
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer for the out-of-order core. It allocates a ROB tag per issued instruction and captures results from the CDBs. It supplies operand values to dispatch for registers whose architectural copy is not yet valid. It retires completed instructions in program order onto the commit port of the GPR and FPR `register_file` instances.

## Interface
Parameters:
- `N_CDB`, default 2: number of CDB write-back ports.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: flush. Synchronous and active-high; clears every entry.
- `issue`, in, 1: allocate one entry this cycle. Must not be asserted while `rob_full`.
- `issue_dest`, in, 1: the instruction writes an architectural register.
- `issue_fpr`, in, 1: the destination is in the FPR file (otherwise the GPR file).
- `issue_arch_num`, in, REG_WIDTH: destination register number.
- `issue_tag`, out, ROB_WIDTH: tag of the entry to be allocated (the tail). Drives `register_file.issue_tag`.
- `rob_full`, out, 1: no free entry.
- `cdb`, in, `cdb_t[N_CDB]`: write-back buses {valid, tag, data}.
- `read_tag`, in, ROB_WIDTH[2]: tags from `register_file.arch_read[*].tag`.
- `rob_read`, out, `cdb_t[2]`: {done, tag, data} of the addressed entries.
- `commit_stall`, in, 1: hold retirement (memory not ready for a store).
- `commit`, out, 1: the head retires this cycle.
- `commit_gpr`, out, 1: `commit` and the destination is a GPR.
- `commit_fpr`, out, 1: `commit` and the destination is an FPR.
- `commit_arch_num`, out, REG_WIDTH: destination register of the head.
- `commit_tag`, out, ROB_WIDTH: head pointer.
- `commit_data`, out, 32: result of the head.

## Operation
- Each entry holds {busy, done, dest, fpr, arch_num, data[31:0]}.
- Pointers:
  - `head` and `tail` are ROB_WIDTH bits and wrap naturally modulo 2^ROB_WIDTH.
  - `count` is ROB_WIDTH+1 bits.
- Flags:
  - `rob_full` = (`count` == 2^ROB_WIDTH).
  - Empty = (`count` == 0).
- Issue:
  - At the edge, write entry[tail] with busy=1, done=0, and the dest/fpr/arch_num fields.
  - Then increment `tail`.
  - `issue_tag` = `tail`, combinational.
- Write-back:
  - For each `cdb[k].valid`, if entry[cdb[k].tag] is busy, set done=1 and data=cdb[k].data.
  - A write-back to a non-busy entry is ignored.
  - Two CDBs carrying the same tag is a protocol error; the higher k wins.
- Commit:
  - `commit` = !empty && entry[head].done && !`commit_stall`. Combinational from the registered state.
  - On commit: clear entry[head].busy and increment `head`.
  - `commit_gpr` = `commit` && dest && !fpr.
  - `commit_fpr` = `commit` && dest && fpr.
  - No-destination entries (stores, branches) still retire and pop.
- Count update: `count` += issue − commit.
- Simultaneous issue and commit: both apply and `count` is unchanged.
  - `rob_full` is registered state, so an entry freed by a commit is not reusable in the same cycle.
- Issue while `rob_full`: ignored (no state change); the bench flags it as an error.
- Reset:
  - `head`, `tail` and `count` go to 0, and every busy/done bit is cleared.
  - Reset overrides issue, CDB write-back and commit in the same cycle.
  - Output values after reset: `commit`/`commit_gpr`/`commit_fpr` = 0, `rob_full` = 0, `issue_tag` = 0, `commit_tag` = 0.
- Read ports: `rob_read[i]` = {entry[read_tag[i]].done, read_tag[i], entry[read_tag[i]].data}.

## Timing
- Allocation latency:
  - `issue_tag` is valid in the issue cycle.
  - The entry is visible as busy from the next cycle.
- Completion latency:
  - A CDB write at edge n makes `done` visible after edge n.
  - `commit` can assert in cycle n+1 at the earliest, and the head pops at edge n+1.
- Throughput: at most 1 issue and 1 commit per cycle; N_CDB write-backs per cycle.
- The commit outputs are combinational from flops; the register file samples them at the same edge the head advances.

## Configuration
- `ROB_READ_BYPASS_EN` defined: each read port also compares `read_tag[i]` against every valid `cdb[k].tag`.
  - On a match, `rob_read[i]` returns done=1 and the CDB data in the same cycle. The highest matching k wins.
- Without the macro: read ports return stored entry state only, so a result is visible one cycle after its CDB write.

## Structure
- Shared package `common.vh`:
  - Already provides `ROB_WIDTH`, `REG_WIDTH` and `cdb_t`.
  - Add `rob_entry_t` {busy, done, dest, fpr, arch_num, data}.
- Single module with no sub-module. The entry array is in flops, because there are N_CDB+1 write ports and 2 asynchronous read ports.

## Test plan
- Reset, then idle → `commit`=0, `rob_full`=0, `issue_tag`=0. Issue GPR r5 → `issue_tag`=0 in that cycle and 1 in the next.
- Issue tags 0,1,2; CDB write tag 2 (0x22), then tag 0 (0x11) → commit tag 0 with data 0x11 the cycle after its write. Tag 1 blocks retirement; after a CDB write to tag 1, tags 1 and 2 commit on consecutive cycles.
- Issue 2^ROB_WIDTH entries → `rob_full`=1 and a further issue is ignored. Complete the head and assert issue in the commit cycle → not accepted; accepted in the next cycle with tag 0 (wrap-around).
- FPR entry f3 and no-destination entry, both done:
  - f3 entry → `commit_fpr`=1, `commit_gpr`=0, `commit_arch_num`=3.
  - No-destination entry → `commit`=1 with both strobes 0.
  - `commit_stall`=1 holds the head for 3 cycles with no pop.
- Both CDBs valid with different tags in one cycle → both entries done. With `ROB_READ_BYPASS_EN`, a `read_tag` equal to `cdb[1].tag` returns done=1 and the CDB data in the same cycle; without the macro it returns done=0.
- 5 entries in flight, assert `reset` together with issue and a CDB write → next cycle: `count` 0, `issue_tag` 0, `commit` 0, and no stale done bits after re-issue.
